// File: rtl/score_submitter.sv
// Queues finished-round results and replays them one at a time onto the
// score-tracker handshake, then reports the tracker's win flags per request.
module score_submitter #(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 2,
    parameter int ADDR_W      = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              SubmitValid,
    input  logic [1:0]        SubmitID,
    input  logic [4:0]        SubmitScore,
    output logic              SubmitReady,
    output logic              ScoreReq,
    output logic [1:0]        PlayerID,
    output logic [4:0]        Score,
    input  logic              PersonalWin,
    input  logic              GlobalWinner,
    output logic              ResultValid,
    output logic [1:0]        ResultID,
    output logic [4:0]        ResultScore,
    output logic              ResultPersonal,
    output logic              ResultGlobal,
    output logic              ResultGlobalNew,
    output logic [ADDR_W:0]   PendingCount,
    output logic              Busy
);
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t              state_reg;
    logic [6:0]          fifo_mem [DEPTH];
    logic [ADDR_W-1:0]   head_reg;
    logic [ADDR_W-1:0]   tail_reg;
    logic [ADDR_W:0]     count_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                prev_global_reg;
    logic                push;
    logic                pop;

    assign SubmitReady  = (count_reg < (ADDR_W+1)'(DEPTH));
    assign push         = SubmitValid & SubmitReady;
    // Pop looks only at pre-edge occupancy, so a fresh push waits one cycle.
    assign pop          = (state_reg == IDLE) && (count_reg != '0);
    assign PendingCount = count_reg;
    assign Busy         = (state_reg != IDLE);

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem[tail_reg] <= {SubmitID, SubmitScore};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + ADDR_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + ADDR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + (ADDR_W+1)'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            prev_global_reg <= 1'b0;
            ScoreReq        <= 1'b0;
            PlayerID        <= '0;
            Score           <= '0;
            ResultValid     <= 1'b0;
            ResultID        <= '0;
            ResultScore     <= '0;
            ResultPersonal  <= 1'b0;
            ResultGlobal    <= 1'b0;
            ResultGlobalNew <= 1'b0;
        end else begin
            ResultValid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        {PlayerID, Score} <= fifo_mem[head_reg];
                        ScoreReq          <= 1'b1;
                        cnt_reg           <= CNT_W'(HOLD_CYCLES - 1);
                        state_reg         <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_reg == '0) begin
                        // Tracker flags have settled by now; latch them with the request.
                        ScoreReq        <= 1'b0;
                        ResultPersonal  <= PersonalWin;
                        ResultGlobal    <= GlobalWinner;
                        ResultGlobalNew <= GlobalWinner & ~prev_global_reg;
                        prev_global_reg <= GlobalWinner;
                        ResultID        <= PlayerID;
                        ResultScore     <= Score;
                        ResultValid     <= 1'b1;
                        cnt_reg         <= CNT_W'(GAP_CYCLES - 1);
                        state_reg       <= GAP;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
